// File: rtl/rs_symbol_packer.sv
// rs_symbol_packer: packs received RS symbols into 128-bit, 16-symbol beats, zero-padding short codewords to 16 beats.
// Optional RS_PACK_LEN_CHECK_EN builds err_len, flagging codewords that reach 256 symbols without sym_last.
module rs_symbol_packer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   sym_in,
    input  logic         sym_valid,
    input  logic         sym_last,
    output logic         sym_ready,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic [3:0]   beat_idx,
    output logic         cw_last,
    output logic         err_len
);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] PAD  = 1'b1;

    logic [0:0]   state;
    logic [3:0]   lane;
    logic [3:0]   beat;
    logic [127:0] asm;
    logic [127:0] merged;
    logic         accept;
    logic         emit;

    assign sym_ready = state == FILL;
    assign accept    = sym_valid && sym_ready;
    assign emit      = accept && (lane == 4'd15 || sym_last);

    always_comb begin
        merged = asm;
        merged[{lane, 3'b000} +: 8] = sym_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            lane      <= 4'd0;
            beat      <= 4'd0;
            asm       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            beat_idx  <= 4'd0;
            cw_last   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            cw_last   <= 1'b0;
            if (state == FILL) begin
                if (emit) begin
                    data_out  <= merged;
                    valid_out <= 1'b1;
                    beat_idx  <= beat;
                    cw_last   <= beat == 4'd15;
                    beat      <= beat + 4'd1;
                    lane      <= 4'd0;
                    asm       <= '0;
                    if (sym_last && beat != 4'd15)
                        state <= PAD;
                end else if (accept) begin
                    asm  <= merged;
                    lane <= lane + 4'd1;
                end
            // hold PAD one extra cycle so sym_ready rises only after beat 15 is shown
            end else if (cw_last) begin
                state <= FILL;
            end else begin
                data_out  <= '0;
                valid_out <= 1'b1;
                beat_idx  <= beat;
                cw_last   <= beat == 4'd15;
                beat      <= beat + 4'd1;
            end
        end
    end

`ifdef RS_PACK_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_len <= 1'b0;
        else
            err_len <= accept && lane == 4'd15 && beat == 4'd15 && !sym_last;
    end
`else
    assign err_len = 1'b0;
`endif

endmodule
